// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  // Controller FSM states; encodings are visible on state_o for debug.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } haz_state_t;

  // Width of the remaining-bubble counter (holds up to LOAD_LAT-1 = 6).
  localparam int BUB_W = 3;

  // True when a used source register matches the load destination.
  function automatic logic rs_match(input logic [4:0] rs,
                                    input logic       use_rs,
                                    input logic [4:0] wrin);
    rs_match = use_rs & (rs == wrin);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the instruction in ID and
// the load in EX. x0 is never a real dependency, so wrin_EX==0 never stalls.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       use_rs1_ID,
  input  logic       use_rs2_ID,
  input  logic [4:0] wrin_EX,
  input  logic       MemRead_EX,
  output logic       hazard
);

  assign hazard = MemRead_EX & (wrin_EX != 5'd0) &
                  (rs_match(rs1_ID, use_rs1_ID, wrin_EX) |
                   rs_match(rs2_ID, use_rs2_ID, wrin_EX));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, taken
// branch squash and data-memory wait freeze. Outputs are Mealy (no latency).
// Optional build macro HAZ_PERF_CNT_EN adds saturating performance counters;
// without it the counter outputs are tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       wrin_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready_MEM,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  haz_state_t       state_r, saved_r, eff_state_s, state_nxt_s, saved_nxt_s;
  logic [BUB_W-1:0] bub_cnt_r, bub_nxt_s;
  logic             hazard_s, mem_wait_s;
  logic             pc_en_s, ifid_en_s, idex_en_s, exmem_en_s;
  logic             ifid_flush_s, idex_bubble_s;

  hazard_detect u_detect (
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .use_rs1_ID (use_rs1_ID),
    .use_rs2_ID (use_rs2_ID),
    .wrin_EX    (wrin_EX),
    .MemRead_EX (MemRead_EX),
    .hazard     (hazard_s)
  );

  assign mem_wait_s = mem_req_MEM & ~mem_ready_MEM;
  // Leaving MEM_WAIT replays the state that was interrupted by the wait.
  assign eff_state_s = (state_r == MEM_WAIT) ? saved_r : state_r;

  // Next-state and pipeline-control decode; wait > branch > load stall.
  always_comb begin
    pc_en_s       = 1'b1;
    ifid_en_s     = 1'b1;
    idex_en_s     = 1'b1;
    exmem_en_s    = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    state_nxt_s   = eff_state_s;
    saved_nxt_s   = saved_r;
    bub_nxt_s     = bub_cnt_r;
    if (mem_wait_s) begin
      pc_en_s     = 1'b0;
      ifid_en_s   = 1'b0;
      idex_en_s   = 1'b0;
      exmem_en_s  = 1'b0;
      state_nxt_s = MEM_WAIT;
      if (state_r != MEM_WAIT) begin
        saved_nxt_s = state_r;
      end else begin
        saved_nxt_s = saved_r;
      end
    end else if (branch_taken_EX) begin
      // Squash wrong-path instrs; an in-progress load stall is abandoned.
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      bub_nxt_s     = {BUB_W{1'b0}};
      state_nxt_s   = RUN;
    end else begin
      case (eff_state_s)
        RUN: begin
          if (hazard_s) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            idex_bubble_s = 1'b1;
            if (LOAD_LAT == 1) begin
              state_nxt_s = RUN;
            end else begin
              bub_nxt_s   = BUB_W'(LOAD_LAT - 1);
              state_nxt_s = LOAD_STALL;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LOAD_STALL: begin
          // Hazard input is ignored here: the load has already left EX.
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_bubble_s = 1'b1;
          if (bub_cnt_r <= BUB_W'(1)) begin
            bub_nxt_s   = {BUB_W{1'b0}};
            state_nxt_s = RUN;
          end else begin
            bub_nxt_s   = bub_cnt_r - BUB_W'(1);
            state_nxt_s = LOAD_STALL;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM, saved-state and bubble-counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= RUN;
      saved_r   <= RUN;
      bub_cnt_r <= {BUB_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      saved_r   <= saved_nxt_s;
      bub_cnt_r <= bub_nxt_s;
    end
  end

  // Reset forces a frozen pipe with NOPs loaded into IF/ID and ID/EX.
  assign pc_en       = ~RESET & pc_en_s;
  assign ifid_en     = ~RESET & ifid_en_s;
  assign idex_en     = ~RESET & idex_en_s;
  assign exmem_en    = ~RESET & exmem_en_s;
  assign ifid_flush  =  RESET | ifid_flush_s;
  assign idex_bubble =  RESET | idex_bubble_s;
  assign state_o     = state_r;

`ifdef HAZ_PERF_CNT_EN
  logic             stall_ev_s, flush_ev_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r, wait_cnt_r;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign stall_ev_s = ~mem_wait_s & ~branch_taken_EX &
                      ((eff_state_s == LOAD_STALL) | ((eff_state_s == RUN) & hazard_s));
  assign flush_ev_s = ~mem_wait_s & branch_taken_EX;

  // Saturating perf counters; the wait counter counts every frozen cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      wait_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_ev_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (mem_wait_s && (wait_cnt_r != CNT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
  assign wait_cnt  = wait_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
  assign wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule
